// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor.
//
// Purpose:
//   Holds the data word type, the 2-bit branch counter states, the BTB entry
//   layout and the prediction verdict values that the hazard unit returns.
//   Modules that need these types import branch_predictor_pkg::*.
//
// Contents:
//   word_t      - 32-bit instruction address / data word
//   bpcnt_t     - 2-bit saturating branch counter states
//   btb_entry_t - one BTB line for the default 16-entry table
//   pred_t      - verdict on a resolved branch's earlier prediction
package branch_predictor_pkg;

    typedef logic [31:0] word_t;

    // Default table size: 16 entries, indexed by pc[5:2].
    localparam int BP_IDX_BITS = 4;

    // The encoding matters. The MSB is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpcnt_t;

    typedef struct packed {
        logic                    valid;
        logic [29-BP_IDX_BITS:0] tag;
        word_t                   target;
        bpcnt_t                  cnt;
    } btb_entry_t;

    typedef enum logic [1:0] {
        PRED_NONE  = 2'b00,
        PRED_RIGHT = 2'b01,
        PRED_WRONG = 2'b10
    } pred_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state logic for one 2-bit saturating branch counter.
//
// Purpose:
//   The counter state lives in the BTB, so this block is purely
//   combinational. A taken outcome moves the state one step towards STRONG_T.
//   A not-taken outcome moves it one step towards STRONG_NT. Both ends hold.
//
// Ports:
//   cnt_i   - current counter state
//   taken_i - resolved branch outcome
//   cnt_o   - counter state after this outcome
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bpcnt_t cnt_i,
    input  logic   taken_i,
    output bpcnt_t cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        unique case (cnt_i)
            STRONG_NT: cnt_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   cnt_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    cnt_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  cnt_o = taken_i ? STRONG_T : WEAK_T;
            default:   cnt_o = WEAK_NT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with one 2-bit counter per entry.
//
// Purpose:
//   This module predicts the fetch PC combinationally in the same cycle.
//   Resolved branches from execute train the table on the clock edge. The
//   module also counts resolved branches and mispredictions. It has no
//   write-to-read bypass. A fetch that hits the index being updated sees
//   the state from before the edge.
//
// Ports:
//   CLK, nRST       - clock (rising edge); asynchronous active-low reset
//   fetch_pc        - PC being fetched this cycle
//   pred_taken      - predict taken (BTB hit and counter MSB set)
//   pred_target     - predicted next PC; fetch_pc+4 when not predicting taken
//   upd_en          - a resolved conditional branch is present this cycle
//   upd_pc          - PC of the resolved branch
//   upd_taken       - actual outcome of the resolved branch
//   upd_target      - actual taken target of the resolved branch
//   br_pred_result  - hazard unit verdict on the earlier prediction
//   branch_cnt      - resolved branches since reset (wraps)
//   mispred_cnt     - PRED_WRONG verdicts since reset (wraps)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = BP_IDX_BITS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  word_t                fetch_pc,
    output logic                 pred_taken,
    output word_t                pred_target,
    input  logic                 upd_en,
    input  word_t                upd_pc,
    input  logic                 upd_taken,
    input  word_t                upd_target,
    input  pred_t                br_pred_result,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    // Same layout as btb_entry_t, with the tag sized by this instance's IDX_BITS.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        bpcnt_t           cnt;
    } entry_t;

    entry_t btb_q [ENTRIES];

    logic [IDX_BITS-1:0] fetchIdx;
    logic [TAG_W-1:0]    fetchTag;
    entry_t              fetchEntry;
    logic                fetchHit;

    logic [IDX_BITS-1:0] updIdx;
    logic [TAG_W-1:0]    updTag;
    entry_t              updEntry;
    logic                updHit;
    bpcnt_t              updCntNext;
    entry_t              updEntry_d;
    logic                updWrite;

    logic [CNT_WIDTH-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_WIDTH-1:0] mispredCnt_q, mispredCnt_d;

    // The low PC bits of the update port are never used for index or tag.
    logic unusedUpdPcLow;
    assign unusedUpdPcLow = ^upd_pc[1:0];

    // Fetch-side lookup. The result depends only on registered table state,
    // so a same-cycle update to this index is not visible yet.
    always_comb begin
        fetchIdx    = fetch_pc[IDX_BITS+1:2];
        fetchTag    = fetch_pc[31:IDX_BITS+2];
        fetchEntry  = btb_q[fetchIdx];
        fetchHit    = fetchEntry.valid && (fetchEntry.tag == fetchTag);
        pred_taken  = fetchHit && fetchEntry.cnt[1];
        pred_target = pred_taken ? fetchEntry.target : (fetch_pc + 32'd4);
    end

    assign updIdx   = upd_pc[IDX_BITS+1:2];
    assign updTag   = upd_pc[31:IDX_BITS+2];
    assign updEntry = btb_q[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == updTag);

    sat_counter2 u_sat_counter2 (
        .cnt_i   (updEntry.cnt),
        .taken_i (upd_taken),
        .cnt_o   (updCntNext)
    );

    // Update-side entry construction. A hit trains the counter in place.
    // A taken miss overwrites the line whether or not it was valid.
    // A not-taken miss leaves the table untouched.
    always_comb begin
        updEntry_d = updEntry;
        updWrite   = 1'b0;
        if (upd_en) begin
            if (updHit) begin
                updWrite       = 1'b1;
                updEntry_d.cnt = updCntNext;
                if (upd_taken) begin
                    updEntry_d.target = upd_target;
                end
            end else if (upd_taken) begin
                updWrite          = 1'b1;
                updEntry_d.valid  = 1'b1;
                updEntry_d.tag    = updTag;
                updEntry_d.target = upd_target;
                updEntry_d.cnt    = WEAK_T;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].cnt    <= WEAK_NT;
            end
        end else if (updWrite) begin
            btb_q[updIdx] <= updEntry_d;
        end
    end

    // The statistics counters wrap freely. A PRED_NONE verdict still counts
    // as a branch.
    always_comb begin
        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (upd_en) begin
            branchCnt_d = branchCnt_q + 1'b1;
            if (br_pred_result == PRED_WRONG) begin
                mispredCnt_d = mispredCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else begin
            branchCnt_q  <= branchCnt_d;
            mispredCnt_q <= mispredCnt_d;
        end
    end

    assign branch_cnt  = branchCnt_q;
    assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor.
//
// Purpose:
//   Drives hand-written stimulus steps and compares the outputs against
//   values computed by hand. A second instance with 4-bit statistics
//   counters shares every input and exercises counter wrap-around.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        CLK;
    logic        nRST;
    word_t       fetch_pc;
    logic        pred_taken;
    word_t       pred_target;
    logic        upd_en;
    word_t       upd_pc;
    logic        upd_taken;
    word_t       upd_target;
    pred_t       br_pred_result;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    logic        predTakenNarrow;
    word_t       predTargetNarrow;
    logic [3:0]  branchCntNarrow;
    logic [3:0]  mispredCntNarrow;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.IDX_BITS(4), .CNT_WIDTH(32)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .br_pred_result (br_pred_result),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    branch_predictor #(.IDX_BITS(4), .CNT_WIDTH(4)) dutNarrow (
        .CLK            (CLK),
        .nRST           (nRST),
        .fetch_pc       (fetch_pc),
        .pred_taken     (predTakenNarrow),
        .pred_target    (predTargetNarrow),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .br_pred_result (br_pred_result),
        .branch_cnt     (branchCntNarrow),
        .mispred_cnt    (mispredCntNarrow)
    );

    // 10 ns clock. Inputs change 1 ns after the rising edge, and outputs are
    // sampled 1 ns after that.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One resolved branch on the update port for one clock. Pass en=0 for an
    // idle step.
    task automatic applyStimulus(input logic en, input word_t pc, input logic taken,
                                 input word_t target, input pred_t result);
        upd_en         = en;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        br_pred_result = result;
        tick();
        upd_en         = 1'b0;
        br_pred_result = PRED_NONE;
    endtask

    task automatic fetchCheck(input string tag, input word_t pc, input logic expTaken,
                              input word_t expTarget);
        fetch_pc = pc;
        #1;
        checkOutput({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, expTaken});
        checkOutput({tag, "_target"}, pred_target, expTarget);
    endtask

    task automatic doReset();
        nRST = 1'b0;
        #3;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        nRST           = 1'b0;
        fetch_pc       = 32'h0000_0040;
        upd_en         = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        br_pred_result = PRED_NONE;

        // Step 1: outputs while reset is held and after it is released.
        #12;
        fetchCheck("inReset", 32'h40, 1'b0, 32'h44);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        fetchCheck("postReset", 32'h40, 1'b0, 32'h44);
        checkOutput("postReset_branchCnt", branch_cnt, 32'd0);
        checkOutput("postReset_mispredCnt", mispred_cnt, 32'd0);

        // Step 2: a taken update allocates the entry as WEAK_T, and a not-taken
        // update then drops it to WEAK_NT.
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, PRED_WRONG);
        fetchCheck("alloc", 32'h40, 1'b1, 32'h100);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, PRED_WRONG);
        fetchCheck("weakNt", 32'h40, 1'b0, 32'h44);

        // Step 3: the counter saturates at STRONG_T and needs two not-taken
        // updates to flip the prediction.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, PRED_RIGHT);
        end
        fetchCheck("strongT", 32'h40, 1'b1, 32'h100);
        checkOutput("step3_branchCnt", branch_cnt, 32'd6);
        checkOutput("step3_mispredCnt", mispred_cnt, 32'd2);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, PRED_WRONG);
        fetchCheck("afterOneNt", 32'h40, 1'b1, 32'h100);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, PRED_WRONG);
        fetchCheck("afterTwoNt", 32'h40, 1'b0, 32'h44);

        // Asynchronous reset clears everything without waiting for a clock edge.
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, PRED_RIGHT);
        fetchCheck("preAsync", 32'h40, 1'b1, 32'h100);
        #2;
        nRST = 1'b0;
        #1;
        fetchCheck("asyncReset", 32'h40, 1'b0, 32'h44);
        checkOutput("asyncReset_branchCnt", branch_cnt, 32'd0);
        checkOutput("asyncReset_mispredCnt", mispred_cnt, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Step 4: 0x40 and 0x80 share index 0. A not-taken miss does not
        // allocate, and PC bits [1:0] are ignored.
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h100, PRED_NONE);
        applyStimulus(1'b1, 32'h80, 1'b1, 32'h200, PRED_NONE);
        fetchCheck("aliasOld", 32'h40, 1'b0, 32'h44);
        fetchCheck("aliasNew", 32'h80, 1'b1, 32'h200);
        applyStimulus(1'b1, 32'hC0, 1'b0, 32'h0, PRED_NONE);
        fetchCheck("ntMissNoAlloc", 32'h80, 1'b1, 32'h200);
        fetchCheck("otherIndex", 32'h84, 1'b0, 32'h88);
        fetchCheck("lowBitsIgnored", 32'h82, 1'b1, 32'h200);
        checkOutput("step4_branchCnt", branch_cnt, 32'd3);

        // Step 5: a same-cycle fetch and update see the state from before the
        // edge. A reset during an update discards that update.
        doReset();
        fetch_pc       = 32'h40;
        upd_en         = 1'b1;
        upd_pc         = 32'h40;
        upd_taken      = 1'b1;
        upd_target     = 32'h300;
        br_pred_result = PRED_RIGHT;
        #1;
        checkOutput("sameCycle_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("sameCycle_target", pred_target, 32'h44);
        tick();
        upd_en = 1'b0;
        fetchCheck("nextCycle", 32'h40, 1'b1, 32'h300);

        upd_en         = 1'b1;
        upd_pc         = 32'h50;
        upd_taken      = 1'b1;
        upd_target     = 32'h400;
        br_pred_result = PRED_WRONG;
        nRST           = 1'b0;
        tick();
        upd_en = 1'b0;
        nRST   = 1'b1;
        tick();
        fetchCheck("resetDuringUpd", 32'h50, 1'b0, 32'h54);
        checkOutput("resetDuringUpd_branchCnt", branch_cnt, 32'd0);

        // Step 6: ten counted updates plus one idle step with a WRONG verdict.
        // PRED_WRONG appears on steps 1, 4 and 8, and step 3 is PRED_NONE.
        for (int s = 0; s < 11; s++) begin
            pred_t res;
            res = PRED_RIGHT;
            if (s == 1 || s == 4 || s == 8 || s == 5) res = PRED_WRONG;
            if (s == 3) res = PRED_NONE;
            applyStimulus(s != 5, 32'h1000 + 32'(s * 4), s[0], 32'h2000, res);
        end
        checkOutput("stats_branchCnt", branch_cnt, 32'd10);
        checkOutput("stats_mispredCnt", mispred_cnt, 32'd3);
        checkOutput("narrow_branchCnt", {28'd0, branchCntNarrow}, 32'd10);
        checkOutput("narrow_mispredCnt", {28'd0, mispredCntNarrow}, 32'd3);

        // Five more updates bring the 4-bit counter to 15, and one more wraps it.
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 32'h3000, 1'b0, 32'h0, PRED_WRONG);
        end
        checkOutput("narrow_at15", {28'd0, branchCntNarrow}, 32'd15);
        applyStimulus(1'b1, 32'h3000, 1'b0, 32'h0, PRED_WRONG);
        checkOutput("narrow_wrap", {28'd0, branchCntNarrow}, 32'd0);
        checkOutput("wide_noWrap", branch_cnt, 32'd16);
        checkOutput("wide_mispred", mispred_cnt, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
